// File: rtl/doomsday_pkg.sv
// Shared definitions for the countdown timer.
//   state_t      : timer FSM states
//   bcd_t        : one 4-bit BCD digit
//   BCD_MAX_*    : largest legal value of a generic digit / the seconds-tens digit
//   sanitise_bcd : clamps each digit of an MM:SS value into its legal range
package doomsday_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_DIGIT    = 4'd9;
  localparam bcd_t BCD_MAX_SEC_TENS = 4'd5;

  function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t max_val);
    return (d > max_val) ? max_val : d;
  endfunction

  // Layout: [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
  function automatic logic [15:0] sanitise_bcd(input logic [15:0] v);
    return {clamp_digit(v[15:12], BCD_MAX_DIGIT),
            clamp_digit(v[11:8],  BCD_MAX_DIGIT),
            clamp_digit(v[7:4],   BCD_MAX_SEC_TENS),
            clamp_digit(v[3:0],   BCD_MAX_DIGIT)};
  endfunction

endpackage

// File: rtl/countdown_bcd_if.sv
// Control/status bundle of the countdown timer.
//   start, stop   : level controls (stop wins when both are high)
//   load          : one-cycle pulse, copies load_value into the count
//   load_value    : BCD MM:SS start time
//   frame_start   : vertical-blank pulse, used only by the frame-sync build
//   big_bin       : displayed BCD MM:SS
//   running       : timer is counting
//   expired       : timer reached 00:00
//   tick          : one-cycle pulse per decrement
// master = controller/display side, slave = timer.
interface countdown_bcd_if;

  logic        start;
  logic        stop;
  logic        load;
  logic [15:0] load_value;
  logic        frame_start;
  logic [15:0] big_bin;
  logic        running;
  logic        expired;
  logic        tick;

  modport master (
    output start, stop, load, load_value, frame_start,
    input  big_bin, running, expired, tick
  );

  modport slave (
    input  start, stop, load, load_value, frame_start,
    output big_bin, running, expired, tick
  );

endinterface

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrementer, chained through borrow for multi-digit counts.
//   digit_in   : current digit
//   dec_in     : decrement request (borrow from the less significant digit)
//   wrap_value : value taken when decrementing from 0 (9, or 5 for seconds tens)
//   digit_out  : next digit
//   borrow_out : decrement request for the next more significant digit
module bcd_digit_dec
  import doomsday_pkg::*;
(
  input  bcd_t digit_in,
  input  logic dec_in,
  input  bcd_t wrap_value,
  output bcd_t digit_out,
  output logic borrow_out
);

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which is what keeps combinational blocks from inferring latches.
  always_comb begin
    digit_out  = digit_in;
    borrow_out = 1'b0;
    if (dec_in) begin
      if (digit_in == 4'd0) begin
        digit_out  = wrap_value;
        borrow_out = 1'b1;
      end else begin
        digit_out = digit_in - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_bcd.sv
// Four-digit BCD MM:SS countdown timer feeding the seven-segment drawer.
//   clk : pixel clock, rising edge
//   rst : synchronous, active-high reset
//   bus : countdown_bcd_if.slave (start/stop/load/load_value/frame_start in,
//         big_bin/running/expired/tick out)
// Parameters: TICK_DIV clk cycles per second (>= 2), RESET_VALUE BCD count at reset.
// Build option: COUNTDOWN_FRAME_SYNC_EN makes big_bin a shadow register that only
// follows the count on frame_start pulses, so digits never change mid-frame.
module countdown_bcd
  import doomsday_pkg::*;
#(
  parameter int          TICK_DIV    = 25_000_000,
  parameter logic [15:0] RESET_VALUE = 16'h0500
) (
  input logic            clk,
  input logic            rst,
  countdown_bcd_if.slave bus
);

  localparam int             PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   count_q, count_d;
  logic          tick_q, tick_d;
  logic          running_q, expired_q;

  // Decrement chain: sec ones -> sec tens -> min ones -> min tens.
  logic [15:0] count_dec;
  logic        b_sec_ones, b_sec_tens, b_min_ones, b_min_tens_unused;

  bcd_digit_dec u_sec_ones (
    .digit_in(count_q[3:0]),   .dec_in(1'b1),       .wrap_value(BCD_MAX_DIGIT),
    .digit_out(count_dec[3:0]),   .borrow_out(b_sec_ones)
  );
  bcd_digit_dec u_sec_tens (
    .digit_in(count_q[7:4]),   .dec_in(b_sec_ones), .wrap_value(BCD_MAX_SEC_TENS),
    .digit_out(count_dec[7:4]),   .borrow_out(b_sec_tens)
  );
  bcd_digit_dec u_min_ones (
    .digit_in(count_q[11:8]),  .dec_in(b_sec_tens), .wrap_value(BCD_MAX_DIGIT),
    .digit_out(count_dec[11:8]),  .borrow_out(b_min_ones)
  );
  // Borrow out of min tens never occurs: 00:00 is not decremented, it expires.
  bcd_digit_dec u_min_tens (
    .digit_in(count_q[15:12]), .dec_in(b_min_ones), .wrap_value(BCD_MAX_DIGIT),
    .digit_out(count_dec[15:12]), .borrow_out(b_min_tens_unused)
  );

  // Next-state logic. Priority is load > stop > start; load is ignored in RUN.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    tick_d  = 1'b0;
    if (bus.load && state_q != RUN) begin
      state_d = IDLE;
      presc_d = '0;
      count_d = sanitise_bcd(bus.load_value);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!bus.stop && bus.start && count_q != 16'h0000) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_d = PAUSED;  // prescaler holds, resume finishes the same second
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
            count_d = count_dec;
            if (count_dec == 16'h0000) state_d = EXPIRED;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PAUSED: begin
          if (!bus.stop && bus.start) state_d = RUN;
        end
        EXPIRED: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      count_q   <= RESET_VALUE;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      running_q <= (state_d == RUN);
      expired_q <= (state_d == EXPIRED);
    end
  end

`ifdef COUNTDOWN_FRAME_SYNC_EN
  logic [15:0] shadow_q;

  always_ff @(posedge clk) begin
    if (rst)                  shadow_q <= RESET_VALUE;
    else if (bus.frame_start) shadow_q <= count_q;
  end

  assign bus.big_bin = shadow_q;
`else
  logic frame_start_unused;
  assign frame_start_unused = bus.frame_start;
  assign bus.big_bin        = count_q;
`endif

  assign bus.running = running_q;
  assign bus.expired = expired_q;
  assign bus.tick    = tick_q;

endmodule

// File: doc/countdown_bcd.md
# countdown_bcd

Four-digit BCD countdown timer (MM:SS) that produces the 16-bit `big_bin` value consumed by the seven-segment glyph drawer in the VGA path. Holds a loadable start time, decrements once per second from a clock-derived prescaler, and flags expiry at 00:00. Runs in the pixel clock domain, so the drawer connects directly with no synchroniser.

## Interface
- `TICK_DIV`, 25_000_000: clk cycles per one-second tick; legal range ≥ 2.
- `RESET_VALUE`, 16'h0500: BCD count loaded on reset (05:00).
- `clk` input 1: pixel clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: level; begin or resume counting.
- `stop` input 1: level; pause counting.
- `load` input 1: single-cycle pulse; copy `load_value` into the count.
- `load_value` input 16: BCD MM:SS, `[15:12]` min tens, `[11:8]` min ones, `[7:4]` sec tens, `[3:0]` sec ones.
- `frame_start` input 1: one-cycle pulse at start of vertical blank; used only with `FRAME_SYNC_EN`.
- `big_bin` output 16: displayed BCD count, same digit layout as `load_value`.
- `running` output 1: high in RUN.
- `expired` output 1: high in EXPIRED.
- `tick` output 1: one-cycle pulse on each decrement.

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED. Reset: IDLE, count = `RESET_VALUE`, prescaler = 0, `big_bin` = `RESET_VALUE`, `running`/`expired`/`tick` = 0.
- IDLE: `start` with count ≠ 0000 → RUN, prescaler cleared to 0. `start` with count = 0000 is ignored.
- RUN: prescaler increments every cycle. At `TICK_DIV-1` it wraps to 0, `tick` pulses, and the count decrements. Decrement to 0000 → EXPIRED. `stop` → PAUSED, prescaler frozen.
- PAUSED: `start` → RUN; prescaler resumes from its held value, so there is no fresh full second.
- EXPIRED: count holds 0000. `load` → IDLE with the new value. `start` is ignored.
- `load` is honoured in IDLE, PAUSED, and EXPIRED, and ignored in RUN. After a load, the state is IDLE and the prescaler is 0.
- Load sanitising, per digit: min tens and min ones and sec ones >9 clamp to 9; sec tens >5 clamps to 5.
- Decrement is BCD with borrow:
  - sec ones 0 → 9, borrow.
  - sec tens 0 → 5, borrow.
  - min ones 0 → 9, borrow.
  - min tens decrements.
  - 99:59 is the maximum value.
- Priority within one cycle: `rst` > `load` > `stop` > `start`. `start` and `stop` high together resolves to stop (enter or stay PAUSED from RUN).

## Timing
- Count register updates on the edge where the prescaler equals `TICK_DIV-1`. `tick` is registered and high for the following cycle.
- Without `FRAME_SYNC_EN`: `big_bin` = count register, so it changes the cycle after the decrement edge. Load latency is 1 cycle.
- `running` and `expired` are registered and reflect state 1 cycle after the causing input.
- Transition to EXPIRED occurs on the same edge the count reaches 0000; `expired` is high the next cycle.

## Configuration
- `COUNTDOWN_FRAME_SYNC_EN` defined: `big_bin` is a shadow register updated from the count only on cycles where `frame_start` = 1. This prevents mid-frame digit tearing, and display latency is up to one frame. Reset still sets the shadow to `RESET_VALUE` immediately.
- Undefined: no shadow register; `big_bin` tracks the count directly and `frame_start` is unused.

## Structure
- Shared package `doomsday_pkg`:
  - state enum (IDLE/RUN/PAUSED/EXPIRED);
  - `bcd_t` 4-bit digit typedef;
  - constants `BCD_MAX_DIGIT` = 9 and `BCD_MAX_SEC_TENS` = 5.
- Sub-module `bcd_digit_dec`: one digit with `dec_in` and a wrap-value input; outputs the next digit and `borrow_out`. Four instances are chained sec ones → min tens.
- Top-level: FSM, prescaler, load sanitiser, and optional shadow register.

## Test plan
All scenarios use `TICK_DIV` = 4 and no frame sync unless stated.
- Reset, then release: `big_bin` = 16'h0500, `running` = 0, `expired` = 0. `start` → `running` = 1; after 4 cycles the first `tick` arrives and `big_bin` = 16'h0459.
- Load 16'h0100, run: after ticks `big_bin` goes 0100 → 0059 → 0058. Load 16'h1000 then one tick gives 0959.
- Load 16'h0002, run: 2 ticks → `big_bin` = 0000 and `expired` = 1. Further `start` leaves `big_bin` = 0000 and `running` = 0.
- Pause and resume: stop 2 cycles into a second, hold 10 cycles (no tick, count frozen), then start; the next `tick` arrives 2 cycles later.
- Edge cases:
  - Load 16'hA7C9 → `big_bin` = 16'h9759 (sanitised).
  - `load` during RUN is ignored.
  - `start` with `stop` both high in RUN → PAUSED.
  - `rst` mid-RUN → 16'h0500, IDLE.
- With `COUNTDOWN_FRAME_SYNC_EN`: a tick without `frame_start` leaves `big_bin` unchanged. A `frame_start` pulse causes `big_bin` to update to the count on the next cycle.
